// File: rtl/rmii_recv_byte_pkg.sv
// rtl/rmii_recv_byte_pkg.sv - shared RMII dibit constants, receive state encoding and helpers
package rmii_recv_byte_pkg;

    // Line dibits seen on RXD[1:0] before the first data byte
    localparam logic [1:0] DIBIT_PRE  = 2'b01;
    localparam logic [1:0] DIBIT_SFD  = 2'b11;
    localparam logic [1:0] DIBIT_FCAR = 2'b10;

    // Receive FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DRAIN    = 2'd3
    } rx_state_t;

    // Counter widths: preamble counter saturates, decimator spans DEC_RELOAD
    localparam int PRE_CNT_W = 4;
    localparam int DEC_CNT_W = 4;

    // Drop a dibit into byte slot idx (LSB-first dibit order)
    function automatic logic [7:0] put_dibit(input logic [7:0] sh,
                                             input logic [1:0] idx,
                                             input logic [1:0] d);
        logic [7:0] r;
        r = sh;
        r[{idx, 1'b0} +: 2] = d;
        return r;
    endfunction

endpackage

// File: rtl/rmii_recv_byte_rx_tick.sv
// rtl/rmii_recv_byte_rx_tick.sv - RMII sample-tick decimator for 100M/10M operation
module rmii_recv_byte_rx_tick
    import rmii_recv_byte_pkg::*;
#(
    parameter int DEC_RELOAD = 9,
    parameter int DEC_CENTER = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rmii_clk,
    input  logic i_fast_eth,
    input  logic i_load,
    output logic o_tick
);

    localparam logic [DEC_CNT_W-1:0] RELOAD_C = DEC_CNT_W'(DEC_RELOAD);
    localparam logic [DEC_CNT_W-1:0] CENTER_C = DEC_CNT_W'(DEC_CENTER);

    logic [DEC_CNT_W-1:0] r_dec_cnt;

    // Count RMII phases; a carrier rise re-centres sampling in the middle of a 10M dibit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dec_cnt <= '0;
        end else if (i_load) begin
            r_dec_cnt <= CENTER_C;
        end else if (i_rmii_clk) begin
            if (r_dec_cnt == '0) begin
                r_dec_cnt <= RELOAD_C;
            end else begin
                r_dec_cnt <= r_dec_cnt - 1'b1;
            end
        end
    end

    assign o_tick = i_rmii_clk & (i_fast_eth | (r_dec_cnt == '0));

endmodule

// File: rtl/rmii_recv_byte.sv
// rtl/rmii_recv_byte.sv - RMII receive byte deserialiser with preamble/SFD stripping and framing
module rmii_recv_byte
    import rmii_recv_byte_pkg::*;
#(
    parameter int PRE_MIN    = 2,
    parameter int DEC_RELOAD = 9,
    parameter int DEC_CENTER = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rmii_clk,
    input  logic       i_fast_eth,
    input  logic       i_rm_crs_dv,
    input  logic [1:0] i_rm_rx_data,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_sof,
    output logic       o_rx_eof,
    output logic       o_rx_err,
    output logic       o_busy
);

    localparam logic [PRE_CNT_W-1:0] PRE_MIN_C = PRE_CNT_W'(PRE_MIN);

    rx_state_t            r_state;
    logic [PRE_CNT_W-1:0] r_pre_cnt;
    logic [1:0]           r_dibit_cnt;
    logic [7:0]           r_sh;
    logic                 r_pend_v;
    logic [1:0]           r_pend;
    logic                 r_first;
    logic [7:0]           r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_sof;
    logic                 r_rx_eof;
    logic                 r_rx_err;

    logic                 w_tick;
    logic                 w_load;
    logic [7:0]           w_sh_a;
    logic [1:0]           w_cnt_a;
    logic                 w_done_a;
    logic [7:0]           w_sh_b;
    logic [1:0]           w_cnt_b;
    logic                 w_done_b;
    logic [7:0]           w_byte;
    logic                 w_done;

    assign w_load = (r_state == ST_IDLE) & i_rmii_clk & i_rm_crs_dv;

    rmii_recv_byte_rx_tick #(
        .DEC_RELOAD (DEC_RELOAD),
        .DEC_CENTER (DEC_CENTER)
    ) u_tick (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rmii_clk (i_rmii_clk),
        .i_fast_eth (i_fast_eth),
        .i_load     (w_load),
        .o_tick     (w_tick)
    );

    // Accept the pending dibit (if any) and then the current one; at most one byte completes per tick
    always_comb begin
        w_sh_a   = r_sh;
        w_cnt_a  = r_dibit_cnt;
        w_done_a = 1'b0;
        if (r_pend_v) begin
            w_sh_a   = put_dibit(r_sh, r_dibit_cnt, r_pend);
            w_cnt_a  = r_dibit_cnt + 2'd1;
            w_done_a = (r_dibit_cnt == 2'd3);
        end
        w_sh_b   = put_dibit(w_sh_a, w_cnt_a, i_rm_rx_data);
        w_cnt_b  = w_cnt_a + 2'd1;
        w_done_b = (w_cnt_a == 2'd3);
        w_byte   = w_done_a ? w_sh_a : w_sh_b;
        w_done   = w_done_a | w_done_b;
    end

    // Receive FSM with shift register, pending dibit and registered framing strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_pre_cnt   <= '0;
            r_dibit_cnt <= '0;
            r_sh        <= '0;
            r_pend_v    <= 1'b0;
            r_pend      <= '0;
            r_first     <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_sof    <= 1'b0;
            r_rx_eof    <= 1'b0;
            r_rx_err    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_sof   <= 1'b0;
            r_rx_eof   <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_pend_v <= 1'b0;
                    if (i_rmii_clk && i_rm_crs_dv) begin
                        r_state   <= ST_PREAMBLE;
                        r_pre_cnt <= '0;
                    end
                end
                ST_PREAMBLE: begin
                    if (w_tick) begin
                        if (!i_rm_crs_dv) begin
                            r_state <= ST_IDLE;
                        end else begin
                            case (i_rm_rx_data)
                                DIBIT_PRE: begin
                                    if (r_pre_cnt != '1) begin
                                        r_pre_cnt <= r_pre_cnt + 1'b1;
                                    end
                                end
                                DIBIT_SFD: begin
                                    if (r_pre_cnt >= PRE_MIN_C) begin
                                        r_state     <= ST_DATA;
                                        r_dibit_cnt <= '0;
                                        r_first     <= 1'b1;
                                        r_pend_v    <= 1'b0;
                                    end else begin
                                        r_pre_cnt <= '0;
                                    end
                                end
                                DIBIT_FCAR: begin
                                    r_state <= ST_DRAIN;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (i_rm_crs_dv) begin
                            r_sh        <= w_sh_b;
                            r_dibit_cnt <= w_cnt_b;
                            r_pend_v    <= 1'b0;
                            if (w_done) begin
                                r_rx_data  <= w_byte;
                                r_rx_valid <= 1'b1;
                                r_rx_sof   <= r_first;
                                r_first    <= 1'b0;
                            end
                        end else if (!r_pend_v) begin
                            r_pend_v <= 1'b1;
                            r_pend   <= i_rm_rx_data;
                        end else begin
                            r_pend_v <= 1'b0;
                            r_rx_eof <= 1'b1;
                            r_rx_err <= (r_dibit_cnt != 2'd0);
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_tick && !i_rm_crs_dv) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_sof   = r_rx_sof;
    assign o_rx_eof   = r_rx_eof;
    assign o_rx_err   = r_rx_err;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rmii_recv_byte.sv
// tb/tb_rmii_recv_byte.sv - scoreboard testbench for rmii_recv_byte
module tb_rmii_recv_byte;

    logic       clk;
    logic       rst_n;
    logic       rmii_clk;
    logic       fast_eth;
    logic       crs_dv;
    logic [1:0] rxd;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_rx_sof;
    logic       o_rx_eof;
    logic       o_rx_err;
    logic       o_busy;

    // event: kind 0 = byte (flag = sof), 1 = eof (flag = err), 2 = illegal strobe combination
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       flag;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  obs_cyc[$];
    int  cyc;
    int  total;
    int  bad;
    int  hold;

    rmii_recv_byte dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rmii_clk   (rmii_clk),
        .i_fast_eth   (fast_eth),
        .i_rm_crs_dv  (crs_dv),
        .i_rm_rx_data (rxd),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .o_rx_sof     (o_rx_sof),
        .o_rx_eof     (o_rx_eof),
        .o_rx_err     (o_rx_err),
        .o_busy       (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rmii_clk = 1'b0;
        forever begin
            @(negedge clk);
            rmii_clk = ~rmii_clk;
        end
    end

    initial cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (o_rx_valid && !o_rx_eof) begin
            obs_q.push_back({2'd0, o_rx_data, o_rx_sof});
            obs_cyc.push_back(cyc);
        end
        if (o_rx_eof && !o_rx_valid) begin
            obs_q.push_back({2'd1, 8'h00, o_rx_err});
            obs_cyc.push_back(cyc);
        end
        if ((o_rx_valid && o_rx_eof) || (o_rx_err && !o_rx_eof) || (o_rx_sof && !o_rx_valid)) begin
            obs_q.push_back({2'd2, 8'h00, 1'b0});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_dibit(input logic crs, input logic [1:0] d);
        crs_dv = crs;
        rxd    = d;
        repeat (2 * hold) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            send_dibit(1'b1, b[2*i +: 2]);
        end
    endtask

    task automatic send_preamble();
        repeat (7) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic send_data(input logic [7:0] b, input logic sof);
        exp_q.push_back({2'd0, b, sof});
        send_byte(b);
    endtask

    task automatic send_end(input logic err);
        exp_q.push_back({2'd1, 8'h00, err});
        send_dibit(1'b0, 2'b00);
        send_dibit(1'b0, 2'b00);
    endtask

    task automatic idle_gap();
        repeat (6) send_dibit(1'b0, 2'b00);
    endtask

    task automatic start_test();
        idle_gap();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        fast_eth = 1'b1;
        crs_dv   = 1'b0;
        rxd      = 2'b00;
        hold     = 1;
        repeat (3) step();
        total++;
        if ({o_rx_data, o_rx_valid, o_rx_sof, o_rx_eof, o_rx_err, o_busy} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {o_rx_data, o_rx_valid, o_rx_sof, o_rx_eof, o_rx_err, o_busy});
        end
        rst_n = 1'b1;
        step();
        if (rmii_clk) step();
    endtask

    task automatic test_frame_100m();
        fast_eth = 1'b1;
        hold     = 1;
        start_test();
        send_preamble();
        send_data(8'hA5, 1'b1);
        send_data(8'h3C, 1'b0);
        send_end(1'b0);
        idle_gap();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL frame100_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL frame100_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_frame_10m();
        fast_eth = 1'b0;
        hold     = 10;
        start_test();
        send_preamble();
        send_data(8'hA5, 1'b1);
        send_data(8'h3C, 1'b0);
        send_end(1'b0);
        idle_gap();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL frame10_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL frame10_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_cyc.size() >= 2) begin
            total++;
            if (obs_cyc[1] - obs_cyc[0] != 80) begin
                bad++;
                $display("FAIL frame10_spacing: got %0d clk want 80 clk", obs_cyc[1] - obs_cyc[0]);
            end
        end
        fast_eth = 1'b1;
        hold     = 1;
    endtask

    task automatic test_carrier_toggle();
        start_test();
        send_preamble();
        send_data(8'h42, 1'b1);
        exp_q.push_back({2'd0, 8'h81, 1'b0});
        send_dibit(1'b0, 2'b01);
        send_dibit(1'b1, 2'b00);
        send_dibit(1'b0, 2'b00);
        send_dibit(1'b1, 2'b10);
        send_end(1'b0);
        idle_gap();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL toggle_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL toggle_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_dribble();
        start_test();
        send_preamble();
        send_data(8'h5A, 1'b1);
        send_dibit(1'b1, 2'b11);
        send_dibit(1'b1, 2'b00);
        send_end(1'b1);
        idle_gap();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL dribble_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL dribble_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_empty_and_short_pre();
        start_test();
        send_preamble();
        send_end(1'b0);
        idle_gap();
        send_dibit(1'b1, 2'b01);
        send_dibit(1'b1, 2'b01);
        send_dibit(1'b1, 2'b11);
        send_dibit(1'b1, 2'b01);
        send_dibit(1'b1, 2'b01);
        send_dibit(1'b1, 2'b11);
        send_data(8'h99, 1'b1);
        send_end(1'b0);
        idle_gap();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL empty_short_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL empty_short_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_false_carrier();
        start_test();
        repeat (4) send_dibit(1'b1, 2'b01);
        repeat (20) send_dibit(1'b1, 2'b10);
        send_dibit(1'b1, 2'b11);
        send_byte(8'h66);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL fcar_busy_high: got %b want 1", o_busy);
        end
        send_dibit(1'b0, 2'b00);
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL fcar_busy_low: got %b want 0", o_busy);
        end
        idle_gap();
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL fcar_no_output: got %0d events want 0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        start_test();
        send_preamble();
        send_data(8'hA5, 1'b1);
        send_dibit(1'b1, 2'b01);
        send_dibit(1'b1, 2'b10);
        rst_n  = 1'b0;
        crs_dv = 1'b0;
        rxd    = 2'b00;
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_busy: got %b want 0", o_busy);
        end
        idle_gap();
        send_preamble();
        send_data(8'h12, 1'b1);
        send_data(8'h34, 1'b0);
        send_end(1'b0);
        idle_gap();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rst_mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rst_mid_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_frame_100m();
        test_frame_10m();
        test_carrier_toggle();
        test_dribble();
        test_empty_and_short_pre();
        test_false_carrier();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
